adder_share_arbiter: RTL and testbench

//  Shares one 10-bit signed adder (sign-extended 11-bit sum, ripple-carry FA chain)

---
 rtl/adder_share_arbiter.sv | 123 ++++++++++++
 tb/tb_adder_share_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   Shares one signed ripple-carry adder among NUM_REQ requesters.
//   - A round-robin arbiter in IDLE picks one requester and latches its operands.
//   - The adder then has one full cycle (CALC) to settle. This keeps the ripple
//     path off the grant path.
//   - The registered sum is offered with the requester index on a valid/ready port.
//
// Handshake: a result transfers on a rising edge where res_valid and res_ready
// are both high. Once res_valid is raised, res/res_id/res_valid hold until that
// edge. res_ready has no effect while res_valid is low.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active high
//   req        per-requester level request, held until its gnt bit
//   a_in/b_in  packed operands, slot i in [i*WIDTH +: WIDTH], two's complement
//   gnt        one-hot grant, one-cycle pulse
//   res        signed sum sext(A)+sext(B), WIDTH+1 bits
//   res_id     requester index owning res
//   res_valid  result available
//   res_ready  consumer accepts the result
module adder_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 10,
   parameter int ID_W    = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*WIDTH-1:0]   a_in,
   input  logic [NUM_REQ*WIDTH-1:0]   b_in,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [WIDTH:0]             res,
   output logic [ID_W-1:0]            res_id,
   output logic                       res_valid,
   input  logic                       res_ready
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  win_idx;
   logic             win_found;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH:0]   ext_a;
   logic [WIDTH:0]   ext_b;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   carry;

   // Round-robin scan: start just after the last winner and wrap around, so the
   // most recent winner has the lowest priority.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!win_found && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
            win_found = 1'b1;
            win_idx   = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         end
      end
   end

   // Sign-extended ripple-carry full-adder chain. Its only inputs are the
   // latched operands, so it has a whole CALC cycle to settle.
   assign ext_a = {op_a[WIDTH-1], op_a};
   assign ext_b = {op_b[WIDTH-1], op_b};

   always_comb begin
      sum   = '0;
      carry = '0;
      for (int i = 0; i <= WIDTH; i++) begin
         sum[i] = ext_a[i] ^ ext_b[i] ^ carry[i];
         if (i < WIDTH) begin
            carry[i+1] = (ext_a[i] & ext_b[i]) | (carry[i] & (ext_a[i] ^ ext_b[i]));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         gnt       <= '0;
         res       <= '0;
         res_id    <= '0;
         res_valid <= 1'b0;
         rr_ptr    <= ID_W'(NUM_REQ - 1);
         op_a      <= '0;
         op_b      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  op_a   <= a_in[win_idx*WIDTH +: WIDTH];
                  op_b   <= b_in[win_idx*WIDTH +: WIDTH];
                  gnt    <= NUM_REQ'(1) << win_idx;
                  rr_ptr <= win_idx;
                  state  <= CALC;
               end
            end
            CALC: begin
               // rr_ptr still holds the winner, so it names the result owner.
               res       <= sum;
               res_id    <= rr_ptr;
               res_valid <= 1'b1;
               gnt       <= '0;
               state     <= DONE;
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter
//   Random and directed traffic for adder_share_arbiter.
//   - A transaction-level model predicts each grant from a round-robin pointer
//     and a "free" flag. When a grant is predicted, the expected {id, sum} is
//     queued, with the sum computed as plain signed integer arithmetic.
//   - A separate posedge monitor pops that queue on every accepted result.
module tb_adder_share_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [39:0] a_in;
   logic [39:0] b_in;
   logic [3:0]  gnt;
   logic [10:0] res;
   logic [1:0]  res_id;
   logic        res_valid;
   logic        res_ready = 1'b0;

   logic [9:0]  a_v [4];
   logic [9:0]  b_v [4];

   assign a_in = {a_v[3], a_v[2], a_v[1], a_v[0]};
   assign b_in = {b_v[3], b_v[2], b_v[1], b_v[0]};

   adder_share_arbiter #(.NUM_REQ(4), .WIDTH(10), .ID_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .gnt       (gnt),
      .res       (res),
      .res_id    (res_id),
      .res_valid (res_valid),
      .res_ready (res_ready)
   );

   // clock
   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [12:0] exp_q [$];

   // model state
   int          ptr_m     = 3;
   bit          free_m    = 1'b1;
   logic [3:0]  exp_gnt   = '0;
   bit          exp_valid = 1'b0;
   bit          held_prev = 1'b0;
   logic [10:0] last_r    = '0;
   logic [1:0]  last_id   = '0;

   // stimulus knobs
   int          req_pct   = 0;
   int          ready_pct = 100;
   logic [3:0]  inj_mask  = '0;
   logic [9:0]  inj_a     = '0;
   logic [9:0]  inj_b     = '0;
   logic [12:0] mon_e;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [10:0] exp_sum(logic [9:0] a, logic [9:0] b);
      int s;
      s = int'($signed(a)) + int'($signed(b));
      return 11'(s);
   endfunction

   function automatic logic [9:0] rnd_op();
      case ($urandom_range(5))
         0:       return 10'h200;
         1:       return 10'h1FF;
         2:       return 10'h3FF;
         3:       return 10'h001;
         default: return 10'($urandom);
      endcase
   endfunction

   // Predict the grant for the coming edge from the current request vector.
   task automatic decide();
      int w;
      w = -1;
      if (free_m && req != 4'b0) begin
         for (int k = 1; k <= 4; k++) begin
            if (w < 0 && req[(ptr_m + k) % 4]) w = (ptr_m + k) % 4;
         end
      end
      if (w >= 0) begin
         exp_gnt = 4'b0001 << w;
         exp_q.push_back({2'(w), exp_sum(a_v[w], b_v[w])});
         ptr_m  = w;
         free_m = 1'b0;
      end else begin
         exp_gnt = '0;
      end
   endtask

   // One cycle: check outputs, drive requesters/ready, advance the model.
   task automatic step();
      logic [3:0] g;
      bit         cur_v;
      @(negedge clk);
      g     = gnt;
      cur_v = exp_valid;
      check("gnt", 32'(g), 32'(exp_gnt));
      check("res_valid", 32'(res_valid), 32'(cur_v));
      if (cur_v && held_prev) begin
         check("res_hold", 32'(res), 32'(last_r));
         check("res_id_hold", 32'(res_id), 32'(last_id));
      end
      if (exp_gnt != 4'b0) exp_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (g[i]) begin
            req[i] = 1'b0;
         end else if (!req[i]) begin
            a_v[i] = rnd_op();
            b_v[i] = rnd_op();
            if ($urandom_range(99) < req_pct) req[i] = 1'b1;
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (inj_mask[i]) begin
            req[i] = 1'b1;
            a_v[i] = inj_a;
            b_v[i] = inj_b;
         end
      end
      inj_mask = '0;
      decide();
      res_ready = ($urandom_range(99) < ready_pct);
      held_prev = cur_v && !res_ready;
      last_r    = res;
      last_id   = res_id;
      if (cur_v && res_ready) begin
         exp_valid = 1'b0;
         free_m    = 1'b1;
      end
   endtask

   task automatic do_reset(int n, logic [3:0] r);
      @(negedge clk);
      rst = 1'b1;
      req = r;
      for (int i = 0; i < 4; i++) begin
         a_v[i] = rnd_op();
         b_v[i] = rnd_op();
      end
      res_ready = 1'b1;
      repeat (n) begin
         @(negedge clk);
         check("rst_gnt", 32'(gnt), 32'h0);
         check("rst_valid", 32'(res_valid), 32'h0);
         check("rst_res", 32'(res), 32'h0);
         check("rst_res_id", 32'(res_id), 32'h0);
      end
      rst       = 1'b0;
      ptr_m     = 3;
      free_m    = 1'b1;
      exp_valid = 1'b0;
      held_prev = 1'b0;
      exp_q.delete();
      decide();
   endtask

   task automatic issue(logic [3:0] mask, logic [9:0] a, logic [9:0] b);
      inj_mask = mask;
      inj_a    = a;
      inj_b    = b;
      repeat (5) step();
   endtask

   // monitor: compares every accepted result against the head of the queue
   always @(posedge clk) begin
      if (!rst && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL result_unexpected: got id=%0d res=%0h expected none", res_id, res);
         end else begin
            mon_e = exp_q.pop_front();
            check("res", 32'(res), 32'(mon_e[10:0]));
            check("res_id", 32'(res_id), 32'(mon_e[12:11]));
         end
      end
   end

   initial begin
      bit found;
      for (int i = 0; i < 4; i++) begin
         a_v[i] = '0;
         b_v[i] = '0;
      end

      // reset with all requests high; requester 0 must win first
      do_reset(2, 4'b1111);
      req_pct   = 0;
      ready_pct = 100;
      repeat (15) step();

      // single operation on requester 2
      issue(4'b0100, 10'd300, 10'd400);

      // signed extremes
      issue(4'b0001, 10'h200, 10'h200);
      issue(4'b0010, 10'h1FF, 10'h1FF);
      issue(4'b1000, 10'h3FF, 10'h001);

      // round robin with everyone requesting
      req_pct = 100;
      repeat (24) step();
      req_pct = 0;
      repeat (12) step();

      // backpressure with requester 1 pending behind requester 0
      ready_pct = 0;
      inj_mask  = 4'b0011;
      inj_a     = rnd_op();
      inj_b     = rnd_op();
      repeat (8) step();
      ready_pct = 100;
      repeat (8) step();

      // reset while a non-zero requester is in CALC
      req_pct = 50;
      found   = 1'b0;
      for (int t = 0; t < 60 && !found; t++) begin
         step();
         if (exp_gnt != 4'b0 && ptr_m != 0) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL midop_setup: got no non-zero grant expected one within 60 cycles");
      end
      req_pct = 0;
      do_reset(1, 4'b1111);
      repeat (15) step();

      // random traffic
      req_pct   = 30;
      ready_pct = 70;
      repeat (2000) step();

      // drain
      req_pct   = 0;
      ready_pct = 100;
      repeat (30) step();
      check("queue_empty", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
